// File: rtl/wire_alu_seq.sv
// Time-multiplexed unsigned add/sub/accumulate engine: one channel per cycle
// through a single shared adder, with shadowed operands and busy/done status.
module wire_alu_seq #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 32
) (
  input  logic                   okClk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [1:0]             mode,
  input  logic                   sat_en,
  input  logic [N_CH*WIDTH-1:0]  op_a,
  input  logic [N_CH*WIDTH-1:0]  op_b,
  output logic [N_CH*WIDTH-1:0]  result,
  output logic [N_CH-1:0]        ovf,
  output logic                   busy,
  output logic                   done
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
  typedef enum logic [1:0] {OP_ADD = 2'd0, OP_SUB = 2'd1, OP_ACC = 2'd2, OP_CLR = 2'd3} op_e;

  // Shared adder: subtraction is x + ~y + 1, so the carry-out is the
  // inverse of borrow. Returns {flag, sum} where flag is carry or borrow.
  function automatic logic [WIDTH:0] alu_step(input logic [WIDTH-1:0] x,
                                              input logic [WIDTH-1:0] y,
                                              input logic             sub);
    logic [WIDTH:0] s;
    s = {1'b0, x} + {1'b0, y ^ {WIDTH{sub}}} + {{WIDTH{1'b0}}, sub};
    return {s[WIDTH] ^ sub, s[WIDTH-1:0]};
  endfunction

  function automatic logic [WIDTH-1:0] saturate(input logic [WIDTH-1:0] r,
                                                input logic             flag,
                                                input logic             sub,
                                                input logic             sat);
    logic [WIDTH-1:0] o;
    o = r;
    if (sat && flag) o = sub ? '0 : '1;
    return o;
  endfunction

  state_e                 state_q, state_d;
  logic [CH_W-1:0]        ch_q, ch_d;
  logic [N_CH*WIDTH-1:0]  result_q, result_d;
  logic [N_CH-1:0]        ovf_q, ovf_d;

  logic [N_CH*WIDTH-1:0]  a_sh_q, b_sh_q;
  op_e                    mode_sh_q;
  logic                   sat_sh_q;
  logic                   load;

  logic [WIDTH-1:0]       a_cur, b_cur, prev_cur;
  logic [WIDTH-1:0]       x_op, y_op, res_cur;
  logic [WIDTH:0]         step;
  logic                   is_sub, flag_cur;
  logic                   last_ch;

  // Operand selection for the channel being processed
  always_comb begin
    a_cur    = '0;
    b_cur    = '0;
    prev_cur = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (ch_q == CH_W'(k)) begin
        a_cur    = a_sh_q[k*WIDTH +: WIDTH];
        b_cur    = b_sh_q[k*WIDTH +: WIDTH];
        prev_cur = result_q[k*WIDTH +: WIDTH];
      end
    end
  end

  // Shared arithmetic and saturation
  always_comb begin
    is_sub = (mode_sh_q == OP_SUB);
    x_op   = (mode_sh_q == OP_ACC) ? prev_cur : a_cur;
    y_op   = (mode_sh_q == OP_ACC) ? a_cur    : b_cur;
    step   = alu_step(x_op, y_op, is_sub);
    if (mode_sh_q == OP_CLR) begin
      res_cur  = '0;
      flag_cur = 1'b0;
    end else begin
      flag_cur = step[WIDTH];
      res_cur  = saturate(step[WIDTH-1:0], step[WIDTH], is_sub, sat_sh_q);
    end
  end

  assign last_ch = (ch_q == CH_W'(N_CH - 1));

  // Sequencer: next state, channel index and result write-back
  always_comb begin
    state_d  = state_q;
    ch_d     = ch_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    load     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = S_RUN;
          ch_d    = '0;
        end
      end
      S_RUN: begin
        for (int k = 0; k < N_CH; k++) begin
          if (ch_q == CH_W'(k)) begin
            result_d[k*WIDTH +: WIDTH] = res_cur;
            ovf_d[k]                   = flag_cur;
          end
        end
        if (last_ch) begin
          state_d = S_DONE;
          ch_d    = '0;
        end else begin
          ch_d = ch_q + CH_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge okClk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ch_q     <= '0;
      result_q <= '0;
      ovf_q    <= '0;
    end else begin
      state_q  <= state_d;
      ch_q     <= ch_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  // Shadow operands hold the request stable for the whole run
  always_ff @(posedge okClk) begin
    if (load) begin
      a_sh_q    <= op_a;
      b_sh_q    <= op_b;
      mode_sh_q <= op_e'(mode);
      sat_sh_q  <= sat_en;
    end
  end

  assign result = result_q;
  assign ovf    = ovf_q;
  assign busy   = (state_q == S_RUN);
  assign done   = (state_q == S_DONE);

endmodule

// File: doc/wire_alu_seq.md
Name: wire_alu_seq

Overview:
- Parametrised, time-multiplexed arithmetic engine for host-controlled wire endpoints.
- Takes N_CH operand pairs from Wire In endpoints and a start pulse from a TriggerIn.
- Computes one channel per cycle through a single shared adder/subtractor.
- Presents registered per-channel results, overflow flags and busy/done status to Wire Out / TriggerOut endpoints.

Parameters:
- N_CH, 4, number of channels; legal range 1..16.
- WIDTH, 32, operand/result width in bits; legal range 8..64.

Ports:
- okClk  input  1  system clock; all logic is on its rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle request pulse, from a TriggerIn.
- mode  input  2  operation select: 0=ADD, 1=SUB, 2=ACC, 3=CLR.
- sat_en  input  1  1 = saturate on overflow; 0 = wrap.
- op_a  input  N_CH*WIDTH  operand A; channel k at [k*WIDTH +: WIDTH].
- op_b  input  N_CH*WIDTH  operand B; same packing as op_a.
- result  output  N_CH*WIDTH  registered results; same packing as op_a.
- ovf  output  N_CH  per-channel overflow/borrow flag of the last operation.
- busy  output  1  high while channels are being processed.
- done  output  1  single-cycle completion pulse.

Behaviour:
- Reset (synchronous, while reset=1):
  - result=0, ovf=0, busy=0, done=0, FSM=IDLE, channel index=0.
  - Reset overrides everything, including mid-RUN: no done pulse is issued and any partially updated results are cleared.
- FSM has three states: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches op_a, op_b, mode and sat_en into shadow registers and moves to RUN with ch=0.
  - start=0 stays in IDLE.
- RUN:
  - busy=1.
  - Each cycle processes channel ch from the shadow registers, writes result[ch] and ovf[ch], then increments ch.
  - After ch=N_CH-1 is written, move to DONE.
- DONE:
  - busy=0, done=1 for exactly one cycle, then return to IDLE.
- start is honoured only in IDLE. It is ignored in RUN and DONE and is not queued.
- Timing, with start sampled at edge t:
  - busy is high in cycles t+1 .. t+N_CH.
  - Channel k result is visible after edge t+1+k.
  - done is high in cycle t+N_CH+1.
  - Next start is accepted from edge t+N_CH+2.
- Changes on op_a, op_b, mode and sat_en after the start edge have no effect on the current run.
- Arithmetic is unsigned and uses a WIDTH+1-bit internal sum.
  - ADD: result=a+b. ovf=carry-out. If sat_en=1 and carry, result=all-ones.
  - SUB: result=a-b. ovf=borrow (a<b). If sat_en=1 and borrow, result=0.
  - ACC: result=result_prev+a; b is ignored. ovf=carry-out. If sat_en=1 and carry, result=all-ones. ovf reflects this step only and is not sticky.
  - CLR: result=0, ovf=0.
- Without saturation, results wrap modulo 2^WIDTH.
- Channels not yet processed in the current run keep their previous values.
- N_CH=1: RUN lasts one cycle. The channel index width is max(1, clog2(N_CH)).

Test Plan:
- ADD wrap (N_CH=4, WIDTH=32): ch0=5+7, ch3=0xFFFFFFFF+2, sat_en=0, start pulse -> result ch0=12, ch3=1; ovf=4'b1000; busy high 4 cycles; done in cycle t+5.
- ADD saturate: same stimulus with sat_en=1 -> ch3=0xFFFFFFFF, ovf[3]=1; other channels unaffected.
- SUB: ch1: 3-10 with sat_en=0 -> 0xFFFFFFF9, ovf[1]=1; repeat with sat_en=1 -> 0, ovf[1]=1; ch2: 10-3 -> 7, ovf[2]=0.
- Accumulate: CLR run, then three ACC runs with a=0x40000000 on all channels -> results 0x40000000, 0x80000000, 0xC0000000, ovf=0. Fourth ACC -> 0 with ovf=all-ones (sat_en=0), or 0xFFFFFFFF with sat_en=1.
- Start while busy: second start 2 cycles after the first, with different operands -> ignored; exactly one done pulse; results match the first operands only. Changing op_a mid-run has no effect.
- Reset mid-run: assert reset in cycle t+2 -> next cycle result=0, ovf=0, busy=0, no done pulse. A fresh start afterwards completes normally with correct values.
